// File: rtl/fc_8b10b_pkg.sv
// Shared constants and table helpers for the FC 8B/10B transmit encoder.
// Provides the K28.5 symbol values, the default idle ordered set, the
// legal-K check and the RD-negative forms of the 5b/6b and 3b/4b codes.
package fc_8b10b_pkg;

  localparam logic [9:0]  K28_5_RDN         = 10'h0FA;
  localparam logic [9:0]  K28_5_RDP         = 10'h305;
  localparam logic [31:0] IDLE_WORD_DEFAULT = 32'hBC95B5B5;
  localparam logic [3:0]  IDLE_K_DEFAULT    = 4'b1000;

  // K28.0-K28.7 plus K23.7, K27.7, K29.7, K30.7
  function automatic logic is_legal_k(input logic [7:0] b);
    logic legal;
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // 5b/6b code (abcdei) as used when RD is negative
  function automatic logic [5:0] enc6_rdn(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;  5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;  5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;  5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;  5'd19: c = 6'b110010;  5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;  5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;  5'd31: c = 6'b101011;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

  // 3b/4b code (fghj) as used when the RD after the 6b sub-block is negative
  function automatic logic [3:0] enc4_rdn(input logic [2:0] y, input logic alt7);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;  3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;  3'd7: c = alt7 ? 4'b0111 : 4'b1110;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fc_8b10b_tx_encoder_if.sv
// Word-in / symbol-out bundle of the FC 8B/10B transmit encoder.
// master: word source (drives in_data/in_k/in_valid, sees everything else).
// slave : the encoder (accepts words, drives in_ready and the symbol outputs).
interface fc_8b10b_tx_encoder_if;
  logic [31:0] in_data;
  logic [3:0]  in_k;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  out_symbol;
  logic        out_word_start;
  logic        out_rd;
  logic        out_code_err;

  modport master (
    output in_data, in_k, in_valid,
    input  in_ready, out_symbol, out_word_start, out_rd, out_code_err
  );

  modport slave (
    input  in_data, in_k, in_valid,
    output in_ready, out_symbol, out_word_start, out_rd, out_code_err
  );
endinterface

// File: rtl/fc_8b10b_enc_byte.sv
// Combinational 8B/10B encoder for a single byte.
// Ports: data/k  - byte and its K request
//        rd_in   - running disparity before the symbol (1 = positive)
//        sym     - 10-bit symbol, bit 9 = a
//        rd_out  - running disparity after the symbol
//        k_err   - K requested for a byte that is not a legal K code
module fc_8b10b_enc_byte
  import fc_8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] sym,
  output logic       rd_out,
  output logic       k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k_legal;
  logic       k28;
  logic [5:0] c6_base;
  logic [5:0] c6;
  logic       bal6;
  logic       rd6;
  logic       alt7;
  logic [3:0] c4_base;
  logic [3:0] c4;
  logic       bal4;
  logic       flip4;

  // Encode 6b then 4b sub-blocks, each chosen by the disparity in force before it
  always_comb begin
    x       = data[4:0];
    y       = data[7:5];
    k_legal = k && is_legal_k(data);
    k_err   = k && !k_legal;
    k28     = k_legal && (x == 5'd28);

    c6_base = k28 ? 6'b001111 : enc6_rdn(x);
    bal6    = ($countones(c6_base) == 32'd3);
    // D.7 is balanced but still has distinct RD- and RD+ forms
    c6      = (rd_in && (!bal6 || (x == 5'd7))) ? ~c6_base : c6_base;
    rd6     = bal6 ? rd_in : ~rd_in;

    // Alternate D.x.7 avoids a run of five equal bits across the 6b/4b seam;
    // K codes with y = 7 always use the alternate form.
    alt7    = k_legal
           || (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))
           || ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    c4_base = enc4_rdn(y, alt7);
    bal4    = ($countones(c4_base) == 32'd2);

    // K28 balanced 4b codes take the inverted pattern, so the whole symbol
    // keeps the comma polarity of its 6b block.
    if (rd6 && (!bal4 || (y == 3'd3))) begin
      flip4 = 1'b1;
    end else if (k28 && !rd6 && bal4 && (y != 3'd3)) begin
      flip4 = 1'b1;
    end else begin
      flip4 = 1'b0;
    end
    c4     = flip4 ? ~c4_base : c4_base;
    sym    = {c6, c4};
    rd_out = bal4 ? rd6 : ~rd6;
  end

endmodule

// File: rtl/fc_8b10b_tx_encoder.sv
// FC 8G transmit 8B/10B encoder: one 10-bit symbol per clock from 32-bit words.
// Ports: clk      - symbol clock
//        reset_n  - asynchronous active-low reset
//        bus      - slave side of fc_8b10b_tx_encoder_if (word in, symbol out)
// A free-running byte counter walks the word register MSB byte first. The word
// register reloads on the cnt 3->0 edge with the offered word, or with the idle
// ordered set when none is offered, so the line is never starved.
module fc_8b10b_tx_encoder
  import fc_8b10b_pkg::*;
#(
  parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEFAULT,
  parameter logic [3:0]  IDLE_K    = IDLE_K_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  fc_8b10b_tx_encoder_if.slave     bus
);

  logic [1:0]  cnt;
  logic [1:0]  cnt_next;
  logic [31:0] word;
  logic [31:0] word_next;
  logic [3:0]  word_k;
  logic [3:0]  word_k_next;
  logic        ready;
  logic        ready_next;
  logic [9:0]  symbol;
  logic        word_start;
  logic        rd;
  logic        code_err;

  logic [7:0]  sel_byte;
  logic        sel_k;
  logic [9:0]  enc_sym;
  logic        enc_rd;
  logic        enc_err;

  // Pick the byte addressed by the counter, [31:24] first
  always_comb begin
    case (cnt)
      2'd0:    begin sel_byte = word[31:24]; sel_k = word_k[3]; end
      2'd1:    begin sel_byte = word[23:16]; sel_k = word_k[2]; end
      2'd2:    begin sel_byte = word[15:8];  sel_k = word_k[1]; end
      default: begin sel_byte = word[7:0];   sel_k = word_k[0]; end
    endcase
  end

  fc_8b10b_enc_byte u_enc (
    .data   (sel_byte),
    .k      (sel_k),
    .rd_in  (rd),
    .sym    (enc_sym),
    .rd_out (enc_rd),
    .k_err  (enc_err)
  );

  // Counter, handshake and word-register next state
  always_comb begin
    cnt_next    = cnt + 2'd1;
    ready_next  = (cnt == 2'd2);
    word_next   = word;
    word_k_next = word_k;
    if (cnt == 2'd3) begin
      if (bus.in_valid && ready) begin
        word_next   = bus.in_data;
        word_k_next = bus.in_k;
      end else begin
        word_next   = IDLE_WORD;
        word_k_next = IDLE_K;
      end
    end else begin
      word_next   = word;
      word_k_next = word_k;
    end
  end

  // State and registered outputs; rd doubles as out_rd
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 2'd0;
      word       <= IDLE_WORD;
      word_k     <= IDLE_K;
      ready      <= 1'b0;
      symbol     <= 10'h000;
      word_start <= 1'b0;
      rd         <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      word       <= word_next;
      word_k     <= word_k_next;
      ready      <= ready_next;
      symbol     <= enc_sym;
      word_start <= (cnt == 2'd0);
      rd         <= enc_rd;
      code_err   <= enc_err;
    end
  end

  assign bus.in_ready       = ready;
  assign bus.out_symbol     = symbol;
  assign bus.out_word_start = word_start;
  assign bus.out_rd         = rd;
  assign bus.out_code_err   = code_err;

endmodule

// File: tb/tb_fc_8b10b_tx_encoder.sv
// Self-checking bench for fc_8b10b_tx_encoder: table-driven 8B/10B stream model,
// directed literal checks and randomized words.
module tb_fc_8b10b_tx_encoder;

  localparam logic [31:0] IDLE_W = 32'hBC95B5B5;
  localparam logic [3:0]  IDLE_KF = 4'b1000;

  // Full 10-bit RD- codes of the legal control characters; RD+ is the inverse
  localparam logic [7:0] K_BYTES [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                          8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [9:0] K_CODES [12] = '{10'h0F4, 10'h0F9, 10'h0F5, 10'h0F3, 10'h0F2, 10'h0FA,
                                          10'h0F6, 10'h0F8, 10'h3A8, 10'h368, 10'h2E8, 10'h1E8};
  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                     4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                     4'b0010, 4'b1010, 4'b0110, 4'b0001};

  logic clk;
  logic reset_n;
  fc_8b10b_tx_encoder_if bus();

  fc_8b10b_tx_encoder #(.IDLE_WORD(IDLE_W), .IDLE_K(IDLE_KF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  // Stream model: position within the current word, the word being sent, RD
  logic [1:0]  m_pos;
  logic [31:0] m_word;
  logic [3:0]  m_k;
  logic        m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {code_err, rd_after, symbol}
  function automatic logic [11:0] model_enc(input logic [7:0] b, input logic kreq, input logic rd);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] s;
    logic       rd6;
    logic       rdn;
    logic [4:0] x;
    logic [2:0] y;
    x = b[4:0];
    y = b[7:5];
    if (kreq) begin
      for (int i = 0; i < 12; i++) begin
        if (K_BYTES[i] == b) begin
          s = rd ? ~K_CODES[i] : K_CODES[i];
          rdn = ($countones(s) > 5) ? 1'b1 : (($countones(s) < 5) ? 1'b0 : rd);
          return {1'b0, rdn, s};
        end
      end
    end
    s6  = rd ? T6P[x] : T6N[x];
    rd6 = ($countones(s6) > 3) ? 1'b1 : (($countones(s6) < 3) ? 1'b0 : rd);
    if (y == 3'd7 && ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                      ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
      s4 = rd6 ? 4'b1000 : 4'b0111;
    else
      s4 = rd6 ? T4P[y] : T4N[y];
    s   = {s6, s4};
    rdn = ($countones(s) > 5) ? 1'b1 : (($countones(s) < 5) ? 1'b0 : rd);
    return {kreq, rdn, s};
  endfunction

  task automatic model_reset();
    m_pos  = 2'd0;
    m_word = IDLE_W;
    m_k    = IDLE_KF;
    m_rd   = 1'b0;
  endtask

  // One symbol period: drive inputs at negedge, advance model, compare after the edge
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k,
                      output logic [9:0] sym, output logic rd_o, output logic err_o);
    logic [11:0] e;
    logic        exp_start;
    int          lane;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_k     = k;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, (m_pos == 2'd3)});
    lane      = 3 - int'(m_pos);
    e         = model_enc(m_word[8*lane +: 8], m_k[lane], m_rd);
    exp_start = (m_pos == 2'd0);
    if (m_pos == 2'd3) begin
      if (v) begin
        m_word = d;
        m_k    = k;
        n_acc++;
      end else begin
        m_word = IDLE_W;
        m_k    = IDLE_KF;
      end
    end
    m_rd  = e[10];
    m_pos = m_pos + 2'd1;
    @(posedge clk);
    #1;
    check("out_symbol",     {22'd0, bus.out_symbol},     {22'd0, e[9:0]});
    check("out_word_start", {31'd0, bus.out_word_start}, {31'd0, exp_start});
    check("out_rd",         {31'd0, bus.out_rd},         {31'd0, e[10]});
    check("out_code_err",   {31'd0, bus.out_code_err},   {31'd0, e[11]});
    sym   = bus.out_symbol;
    rd_o  = bus.out_rd;
    err_o = bus.out_code_err;
  endtask

  task automatic check_zero_outputs();
    check("rst_symbol", {22'd0, bus.out_symbol}, 32'd0);
    check("rst_start",  {31'd0, bus.out_word_start}, 32'd0);
    check("rst_rd",     {31'd0, bus.out_rd}, 32'd0);
    check("rst_err",    {31'd0, bus.out_code_err}, 32'd0);
    check("rst_ready",  {31'd0, bus.in_ready}, 32'd0);
  endtask

  // Step idle until the next cycle is the accept cycle
  task automatic align();
    logic [9:0] s;
    logic r, er;
    while (m_pos != 2'd3) step(1'b0, 32'd0, 4'd0, s, r, er);
  endtask

  // Offer one word then return its four symbols, RDs and error flags
  task automatic send_word(input logic [31:0] d, input logic [3:0] k,
                           output logic [9:0] s [4], output logic r [4], output logic er [4]);
    logic [9:0] s0;
    logic r0, e0;
    align();
    step(1'b1, d, k, s0, r0, e0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'hDEADBEEF, 4'hF, s[i], r[i], er[i]);
  endtask

  task automatic gen_word(output logic [31:0] d, output logic [3:0] k);
    int r;
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        d[8*i +: 8] = K_BYTES[$urandom_range(0, 11)];
        k[i] = 1'b1;
      end else begin
        d[8*i +: 8] = 8'($urandom);
        k[i] = (r == 1);
      end
    end
  endtask

  initial begin : main
    logic [9:0]  s [4];
    logic        r [4];
    logic        er [4];
    logic [9:0]  s1;
    logic        r1, e1;
    logic [31:0] d;
    logic [3:0]  k;
    logic [9:0]  idle_exp [4];
    idle_exp = '{10'h0FA, 10'h2A2, 10'h2AA, 10'h2AA};

    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.in_k     = 4'd0;
    model_reset();
    #12;
    check_zero_outputs();
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Idle stream right after reset
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 4'd0, s[i], r[i], er[i]);
    for (int i = 0; i < 4; i++) begin
      check("idle_sym", {22'd0, s[i]}, {22'd0, idle_exp[i]});
      check("idle_rd",  {31'd0, r[i]}, {31'd0, (i == 0)});
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 4'd0, s1, r1, e1);

    // D0.0 x4 at RD-, then idle resumes
    send_word(32'h00000000, 4'b0000, s, r, er);
    for (int i = 0; i < 4; i++) begin
      check("d00_sym", {22'd0, s[i]}, 32'h274);
      check("d00_rd",  {31'd0, r[i]}, 32'd0);
    end
    step(1'b0, 32'd0, 4'd0, s1, r1, e1);
    check("d00_idle", {22'd0, s1}, 32'h0FA);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 4'd0, s1, r1, e1);

    // Illegal K request on byte 0: encoded as data, error on that symbol only
    send_word(32'h00000000, 4'b1000, s, r, er);
    check("kerr_sym0", {22'd0, s[0]}, 32'h274);
    for (int i = 0; i < 4; i++) check("kerr_flag", {31'd0, er[i]}, {31'd0, (i == 0)});

    // K28.5 D0.0 D0.0 D0.0 leaves RD+, idle then starts with 0x305
    send_word(32'hBC000000, 4'b1000, s, r, er);
    check("k285_sym0", {22'd0, s[0]}, 32'h0FA);
    for (int i = 1; i < 4; i++) check("k285_d00", {22'd0, s[i]}, 32'h18B);
    check("k285_rd", {31'd0, r[3]}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 4'd0, s[i], r[i], er[i]);
    check("idlep_0", {22'd0, s[0]}, 32'h305);
    check("idlep_1", {22'd0, s[1]}, 32'h2AD);
    check("idlep_2", {22'd0, s[2]}, 32'h2AA);
    check("idlep_3", {22'd0, s[3]}, 32'h2AA);

    // in_valid held: eight words back-to-back, data scrambled in non-ready cycles
    align();
    n_acc = 0;
    for (int i = 0; i < 32; i++) begin
      gen_word(d, k);
      step(1'b1, d, k, s1, r1, e1);
    end
    check("burst_accepts", n_acc, 32'd8);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 4'd0, s1, r1, e1);

    // Random valid / data / K mix
    for (int i = 0; i < 600; i++) begin
      gen_word(d, k);
      step(1'($urandom_range(0, 1)), d, k, s1, r1, e1);
    end

    // Reset during byte 2 of a data word
    align();
    step(1'b1, 32'h11223344, 4'b0000, s1, r1, e1);
    step(1'b0, 32'd0, 4'd0, s1, r1, e1);
    step(1'b0, 32'd0, 4'd0, s1, r1, e1);
    reset_n = 1'b0;
    #1;
    check_zero_outputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 4'd0, s[i], r[i], er[i]);
    check("rst_restart_sym", {22'd0, s[0]}, 32'h0FA);
    check("rst_restart_rd",  {31'd0, r[0]}, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 4'd0, s1, r1, e1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
